uart_cmd_assembler: RTL and testbench

Controller that sequences the UART receiver and turns its byte stream into 16-bit commands for the command processor.
- Accepts each received byte and returns the receiver's clear-ready strobe in the same cycle.
- Pairs bytes high-then-low, with an inter-byte timeout that resynchronises framing.
- Queues completed commands in a small FIFO, using a ready/clear handshake toward the consumer.

---
 rtl/uart_cmd_assembler.sv | 109 ++++++++++
 tb/tb_uart_cmd_assembler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// Assembles pairs of UART bytes (high then low) into 16-bit commands and queues
// them in a small circular FIFO with a ready/clear handshake toward the consumer.
module uart_cmd_assembler #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_rdy,
    output logic                         clr_rx_rdy,
    output logic [15:0]                  cmd,
    output logic                         cmd_rdy,
    input  logic                         clr_cmd_rdy,
    output logic [$clog2(CMD_DEPTH):0]   cmd_cnt,
    output logic                         timeout_err,
    output logic                         overflow
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {HIGH, LOW} state_t;

    state_t         state_q, state_d;
    logic [15:0]    timer_q, timer_d;
    logic [7:0]     high_q, high_d;
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    mem_q [CMD_DEPTH];

    logic push, pop, full, push_ok, expire;

    // A received byte always takes priority over an expiring timer in LOW.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        high_d  = high_q;
        push    = 1'b0;
        expire  = 1'b0;
        case (state_q)
            HIGH: begin
                if (rx_rdy) begin
                    high_d  = rx_data;
                    timer_d = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rx_rdy) begin
                    push    = 1'b1;
                    state_d = HIGH;
                end else if (timer_q == TIMER_LAST) begin
                    expire  = 1'b1;
                    state_d = HIGH;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = HIGH;
        endcase
    end

    always_comb begin
        full    = (cnt_q == CW'(CMD_DEPTH));
        pop     = clr_cmd_rdy && (cnt_q != '0);
        push_ok = push && (!full || pop);
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(pop);
        ovf_d   = ovf_q | (push & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HIGH;
            timer_q <= '0;
            high_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            high_q  <= high_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_q] <= {high_q, rx_data};
        end
    end

    assign clr_rx_rdy  = rx_rdy;
    assign cmd_rdy     = (cnt_q != '0);
    assign cmd         = cmd_rdy ? mem_q[rd_q] : 16'h0000;
    assign cmd_cnt     = cnt_q;
    assign timeout_err = expire && !rst;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a queue-based reference model of the command assembler.
module tb_uart_cmd_assembler;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxRdy;
    logic        clrRxRdy;
    logic [15:0] cmd;
    logic        cmdRdy;
    logic        clrCmdRdy;
    logic [2:0]  cmdCnt;
    logic        timeoutErr;
    logic        overflow;

    uart_cmd_assembler #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rxData),
        .rx_rdy      (rxRdy),
        .clr_rx_rdy  (clrRxRdy),
        .cmd         (cmd),
        .cmd_rdy     (cmdRdy),
        .clr_cmd_rdy (clrCmdRdy),
        .cmd_cnt     (cmdCnt),
        .timeout_err (timeoutErr),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNo     = 0;
    int clrPulses   = 0;
    int errCount    = 0;
    int errAt       = -1;

    // Reference model: pending high byte with its age in cycles, a command queue, sticky overflow.
    bit          mPend = 1'b0;
    logic [7:0]  mHi   = '0;
    int          mAge  = 0;
    logic [15:0] mQ[$];
    bit          mOvf  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycleNo);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic [7:0] d, input logic popReq);
        bit expErr;
        bit popping;
        rst       = r;
        rxRdy     = rdy;
        rxData    = d;
        clrCmdRdy = popReq;
        @(negedge clk);
        expErr = !r && mPend && !rdy && (mAge == TMO);
        checkOutput("clr_rx_rdy", 32'(clrRxRdy), 32'(rdy));
        checkOutput("timeout_err", 32'(timeoutErr), 32'(expErr));
        checkOutput("cmd_rdy", 32'(cmdRdy), 32'(mQ.size() != 0));
        checkOutput("cmd", 32'(cmd), (mQ.size() != 0) ? 32'(mQ[0]) : 32'h0);
        checkOutput("cmd_cnt", 32'(cmdCnt), 32'(mQ.size()));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        if (clrRxRdy) clrPulses++;
        if (timeoutErr) begin
            errCount++;
            errAt = cycleNo;
        end
        if (r) begin
            mPend = 1'b0;
            mAge  = 0;
            mQ.delete();
            mOvf  = 1'b0;
        end else begin
            popping = popReq && (mQ.size() != 0);
            if (popping) void'(mQ.pop_front());
            if (mPend && rdy) begin
                if (mQ.size() < DEPTH) mQ.push_back({mHi, d});
                else mOvf = 1'b1;
                mPend = 1'b0;
            end else if (mPend && mAge == TMO) begin
                mPend = 1'b0;
            end else if (mPend) begin
                mAge++;
            end else if (rdy) begin
                mPend = 1'b1;
                mHi   = d;
                mAge  = 1;
            end
        end
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic popReq);
        applyStimulus(1'b0, 1'b1, b, popReq);
    endtask

    task automatic idle(input int n, input logic popReq);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, popReq);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int k;
        int errBase;
        int rxProb;
        int popProb;
        rst = 1'b1; rxRdy = 1'b0; rxData = '0; clrCmdRdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic pairing and pop
        doReset();
        checkOutput("reset cmd_rdy", 32'(cmdRdy), 32'h0);
        checkOutput("reset cmd", 32'(cmd), 32'h0);
        checkOutput("reset cmd_cnt", 32'(cmdCnt), 32'h0);
        clrPulses = 0;
        sendByte(8'hA5, 1'b0);
        sendByte(8'h3C, 1'b0);
        checkOutput("pair clr pulses", 32'(clrPulses), 32'd2);
        checkOutput("pair cmd", 32'(cmd), 32'hA53C);
        checkOutput("pair cmd_rdy", 32'(cmdRdy), 32'h1);
        checkOutput("pair cmd_cnt", 32'(cmdCnt), 32'h1);
        idle(1, 1'b1);
        checkOutput("pop cmd_rdy", 32'(cmdRdy), 32'h0);
        checkOutput("pop cmd", 32'(cmd), 32'h0);

        // Timeout resynchronises framing
        errBase = errCount;
        k = cycleNo;
        sendByte(8'h12, 1'b0);
        idle(150, 1'b0);
        checkOutput("timeout pulses", 32'(errCount - errBase), 32'd1);
        checkOutput("timeout cycle", 32'(errAt), 32'(k + TMO));
        sendByte(8'h34, 1'b0);
        sendByte(8'h56, 1'b0);
        checkOutput("resync cmd", 32'(cmd), 32'h3456);
        checkOutput("resync cmd_cnt", 32'(cmdCnt), 32'h1);
        idle(1, 1'b1);

        // Overflow with five commands and no pops
        for (int i = 1; i <= 5; i++) begin
            sendByte(8'(i), 1'b0);
            sendByte(8'(i), 1'b0);
        end
        checkOutput("full cmd_cnt", 32'(cmdCnt), 32'd4);
        checkOutput("overflow set", 32'(overflow), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain order", 32'(cmd), 32'({8'(i), 8'(i)}));
            idle(1, 1'b1);
        end
        checkOutput("drained cmd_rdy", 32'(cmdRdy), 32'h0);
        checkOutput("overflow sticky", 32'(overflow), 32'h1);
        doReset();
        checkOutput("overflow cleared", 32'(overflow), 32'h0);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) begin
            sendByte(8'h10 + 8'(i), 1'b0);
            sendByte(8'h20 + 8'(i), 1'b0);
        end
        sendByte(8'hBE, 1'b0);
        sendByte(8'hEF, 1'b1);
        checkOutput("full push+pop cnt", 32'(cmdCnt), 32'd4);
        checkOutput("full push+pop ovf", 32'(overflow), 32'h0);
        idle(3, 1'b1);
        checkOutput("beef last", 32'(cmd), 32'hBEEF);
        for (int i = 0; i < 10; i++) begin
            sendByte(8'h40 + 8'(i), 1'b0);
            sendByte(8'h80 + 8'(i), 1'b1);
        end
        idle(2, 1'b1);

        // Low byte in the very last timer cycle wins over the timeout
        doReset();
        errBase = errCount;
        sendByte(8'h9A, 1'b0);
        idle(TMO - 1, 1'b0);
        sendByte(8'hBC, 1'b0);
        checkOutput("edge no timeout", 32'(errCount - errBase), 32'd0);
        checkOutput("edge cmd", 32'(cmd), 32'h9ABC);

        // Reset mid-command drops the pending high byte
        doReset();
        sendByte(8'h77, 1'b0);
        doReset();
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        checkOutput("rst mid cmd", 32'(cmd), 32'h1122);
        checkOutput("rst mid ovf", 32'(overflow), 32'h0);
        checkOutput("rst mid cnt", 32'(cmdCnt), 32'h1);

        // Randomized traffic
        rxProb  = 20;
        popProb = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: rxProb = 1;
                    1: rxProb = 20;
                    default: rxProb = 70;
                endcase
                popProb = int'($urandom_range(5, 80));
            end
            applyStimulus(($urandom_range(0, 299) == 0),
                          (int'($urandom_range(0, 99)) < rxProb),
                          8'($urandom),
                          (int'($urandom_range(0, 99)) < popProb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
